// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// reg_file_pkg : shared word type and popcount helper for the register file
// Rev 1.0
// ============================================================================
package reg_file_pkg;

   localparam int WORD_W    = 64;
   localparam int MAX_DEPTH = 64;   // largest busy vector popcount accepts
   localparam int CNT_W     = 7;

   typedef logic [WORD_W-1:0] word_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [MAX_DEPTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard : per-register busy bits for in-flight loads, busy count
// Rev 1.0
// ============================================================================
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int NRD    = 3,
   parameter bit BYPASS = 1'b1,
   localparam int ADDRW = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr1_en,
   input  logic [ADDRW-1:0]     wr1_addr,
   input  logic                 claim_en,
   input  logic [ADDRW-1:0]     claim_addr,
   input  logic [NRD*ADDRW-1:0] rd_addr,
   output logic [NRD-1:0]       rd_busy,
   output logic [ADDRW:0]       busy_cnt
);

   logic [DEPTH-1:0]     busy_q;
   logic [DEPTH-1:0]     busy_d;
   logic [ADDRW:0]       busy_cnt_q;
   logic [ADDRW:0]       busy_cnt_d;
   logic [MAX_DEPTH-1:0] w_busy_pad;

   // Claim is applied after the clear so a back-to-back load keeps the bit set.
   always_comb begin
      busy_d = busy_q;
      if (wr1_en && (wr1_addr != '0)) begin
         busy_d[wr1_addr] = 1'b0;
      end
      if (claim_en && (claim_addr != '0)) begin
         busy_d[claim_addr] = 1'b1;
      end
      w_busy_pad             = '0;
      w_busy_pad[DEPTH-1:0]  = busy_d;
      busy_cnt_d             = (ADDRW+1)'(popcount(w_busy_pad));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDRW-1:0] w_a;
      assign w_a = rd_addr[i*ADDRW +: ADDRW];
      if (BYPASS) begin : g_byp
         assign rd_busy[i] = (w_a != '0) && busy_q[w_a] && !(wr1_en && (wr1_addr == w_a));
      end else begin : g_nobyp
         assign rd_busy[i] = (w_a != '0) && busy_q[w_a];
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// reg_file_sb : NRD-read, two-write register file with load scoreboard
// Rev 1.0
// ============================================================================
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int NRD    = 3,
   parameter bit BYPASS = 1'b1,
   localparam int ADDRW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr0_en,
   input  logic [ADDRW-1:0]      wr0_addr,
   input  logic [WORD_W-1:0]     wr0_data,
   input  logic                  wr1_en,
   input  logic [ADDRW-1:0]      wr1_addr,
   input  logic [WORD_W-1:0]     wr1_data,
   input  logic                  claim_en,
   input  logic [ADDRW-1:0]      claim_addr,
   input  logic [NRD*ADDRW-1:0]  rd_addr,
   output logic [NRD*WORD_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   output logic [ADDRW:0]        busy_cnt,
   output logic                  wr_conflict
);

   word_t regs_q [DEPTH];
   logic  conflict_q;
   logic  w_wr0_ok;
   logic  w_wr1_ok;
   logic  w_conflict;

   assign w_wr0_ok   = wr0_en && (wr0_addr != '0);
   assign w_wr1_ok   = wr1_en && (wr1_addr != '0);
   assign w_conflict = w_wr0_ok && w_wr1_ok && (wr0_addr == wr1_addr);

   // wr0 is assigned last so it owns the entry when both ports collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= '0;
         end
         conflict_q <= 1'b0;
      end else begin
         if (w_wr1_ok) begin
            regs_q[wr1_addr] <= wr1_data;
         end
         if (w_wr0_ok) begin
            regs_q[wr0_addr] <= wr0_data;
         end
         conflict_q <= w_conflict;
      end
   end

   assign wr_conflict = conflict_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDRW-1:0] w_a;
      assign w_a = rd_addr[i*ADDRW +: ADDRW];
      if (BYPASS) begin : g_byp
         always_comb begin
            if (w_a == '0) begin
               rd_data[i*WORD_W +: WORD_W] = '0;
            end else if (wr0_en && (wr0_addr == w_a)) begin
               rd_data[i*WORD_W +: WORD_W] = wr0_data;
            end else if (wr1_en && (wr1_addr == w_a)) begin
               rd_data[i*WORD_W +: WORD_W] = wr1_data;
            end else begin
               rd_data[i*WORD_W +: WORD_W] = regs_q[w_a];
            end
         end
      end else begin : g_nobyp
         assign rd_data[i*WORD_W +: WORD_W] = (w_a == '0) ? '0 : regs_q[w_a];
      end
   end

   reg_scoreboard #(
      .DEPTH  (DEPTH),
      .NRD    (NRD),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .wr1_en     (wr1_en),
      .wr1_addr   (wr1_addr),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .rd_addr    (rd_addr),
      .rd_busy    (rd_busy),
      .busy_cnt   (busy_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// tb_reg_file_sb : bypass and non-bypass instances checked against an array model
// Rev 1.0
// ============================================================================
module tb_reg_file_sb;

   localparam int NRD = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr0_en, wr1_en, claim_en;
   logic [3:0]   wr0_addr, wr1_addr, claim_addr;
   logic [63:0]  wr0_data, wr1_data;
   logic [15:0]  rd_addr;
   logic [255:0] rd_data_b, rd_data_n;
   logic [3:0]   rd_busy_b, rd_busy_n;
   logic [4:0]   busy_cnt_b, busy_cnt_n;
   logic         wr_conflict_b, wr_conflict_n;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DEPTH(16), .NRD(NRD), .BYPASS(1'b1)) u_dut_byp (
      .clk(clk), .rst(rst),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .busy_cnt(busy_cnt_b), .wr_conflict(wr_conflict_b)
   );

   reg_file_sb #(.DEPTH(16), .NRD(NRD), .BYPASS(1'b0)) u_dut_nobyp (
      .clk(clk), .rst(rst),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .busy_cnt(busy_cnt_n), .wr_conflict(wr_conflict_n)
   );

   // Architectural model: what each register holds and which loads are outstanding.
   logic [63:0] m_mem [16];
   bit          m_busy [16];
   bit          m_conf  = 1'b0;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
         end
         m_conf  = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_conf = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != 0);
         if (wr1_en && wr1_addr != 0) begin
            m_mem[wr1_addr]  = wr1_data;
            m_busy[wr1_addr] = 1'b0;
         end
         if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
         if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
      end
   end

   function automatic logic [63:0] exp_rd(input bit byp, input logic [3:0] a);
      if (a == 0) return '0;
      if (byp && wr0_en && wr0_addr == a) return wr0_data;
      if (byp && wr1_en && wr1_addr == a) return wr1_data;
      return m_mem[a];
   endfunction

   function automatic bit exp_busy(input bit byp, input logic [3:0] a);
      if (a == 0) return 1'b0;
      if (byp && wr1_en && wr1_addr == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic int exp_cnt();
      int c = 0;
      for (int k = 0; k < 16; k++) c += int'(m_busy[k]);
      return c;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      logic [3:0] a;
      if (m_valid && !rst) begin
         for (int p = 0; p < NRD; p++) begin
            a = rd_addr[p*4 +: 4];
            check($sformatf("byp rd_data%0d", p), rd_data_b[p*64 +: 64], exp_rd(1'b1, a));
            check($sformatf("nobyp rd_data%0d", p), rd_data_n[p*64 +: 64], exp_rd(1'b0, a));
            check($sformatf("byp rd_busy%0d", p), 64'(rd_busy_b[p]), 64'(exp_busy(1'b1, a)));
            check($sformatf("nobyp rd_busy%0d", p), 64'(rd_busy_n[p]), 64'(exp_busy(1'b0, a)));
         end
         check("byp busy_cnt", 64'(busy_cnt_b), 64'(exp_cnt()));
         check("nobyp busy_cnt", 64'(busy_cnt_n), 64'(exp_cnt()));
         check("byp wr_conflict", 64'(wr_conflict_b), 64'(m_conf));
         check("nobyp wr_conflict", 64'(wr_conflict_n), 64'(m_conf));
      end
   end

   task automatic idle();
      rst = 1'b0;
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      claim_en = 1'b0; claim_addr = '0;
      rd_addr = '0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic rd4(input logic [3:0] a0, a1, a2, a3);
      rd_addr = {a3, a2, a1, a0};
   endtask

   task automatic wr0(input logic [3:0] a, input logic [63:0] d);
      wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
   endtask

   task automatic wr1(input logic [3:0] a, input logic [63:0] d);
      wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
   endtask

   task automatic claim(input logic [3:0] a);
      claim_en = 1'b1; claim_addr = a;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [63:0] v;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; idle();
      rd4(0, 5, 1, 15); settle();
      for (int p = 0; p < NRD; p++) check("lit reset rd", rd_data_b[p*64 +: 64], 64'h0);
      check("lit reset busy_cnt", 64'(busy_cnt_b), 64'd0);

      // Reset arriving mid-write discards the write and the claim.
      nxt(); wr0(5, 64'h5555);
      nxt(); rst = 1'b1; wr0(5, 64'hDEAD); wr1(0, 64'hDEAD); claim(5);
      nxt(); rd4(5, 0, 5, 0); settle();
      check("lit rst-mid-write r5 byp", rd_data_b[63:0], 64'h0);
      check("lit rst-mid-write r5 nobyp", rd_data_n[63:0], 64'h0);
      check("lit rst-mid-write busy_cnt", 64'(busy_cnt_b), 64'd0);
      wr0(5, 64'hDEAD); wr1(0, 64'hDEAD);
      nxt(); wr0(0, 64'h1); wr1(0, 64'h2);
      nxt(); rd4(5, 0, 5, 0); settle();
      check("lit r5 after write", rd_data_n[63:0], 64'hDEAD);
      check("lit r0 reads zero", rd_data_n[127:64], 64'h0);
      check("lit r0 no conflict", 64'(wr_conflict_b), 64'd0);

      // Same-cycle bypass vs stored-only read.
      nxt(); wr0(3, 64'h1234); rd4(3, 3, 0, 0); settle();
      check("lit bypass same cycle", rd_data_b[63:0], 64'h1234);
      check("lit nobypass old value", rd_data_n[63:0], 64'h0);
      nxt(); rd4(3, 0, 0, 0); settle();
      check("lit nobypass next cycle", rd_data_n[63:0], 64'h1234);

      // wr0/wr1 collision on a busy register.
      nxt(); claim(7);
      nxt(); wr0(7, 64'hAA); wr1(7, 64'hBB); rd4(7, 0, 0, 0); settle();
      check("lit collide bypass data", rd_data_b[63:0], 64'hAA);
      check("lit collide byp busy", 64'(rd_busy_b[0]), 64'd0);
      check("lit collide nobyp busy", 64'(rd_busy_n[0]), 64'd1);
      nxt(); rd4(7, 0, 0, 0); settle();
      check("lit collide stored", rd_data_n[63:0], 64'hAA);
      check("lit collide conflict", 64'(wr_conflict_b), 64'd1);
      check("lit collide busy_cnt", 64'(busy_cnt_b), 64'd0);
      nxt(); settle();
      check("lit conflict one cycle", 64'(wr_conflict_b), 64'd0);

      // Scoreboard claim/clear ordering.
      nxt(); claim(2);
      nxt(); claim(4);
      nxt(); rd4(2, 4, 1, 0); settle();
      check("lit two claims cnt", 64'(busy_cnt_b), 64'd2);
      check("lit two claims rd_busy", 64'(rd_busy_b), 64'b0011);
      nxt(); claim(2); wr1(2, 64'h22); rd4(2, 4, 0, 0); settle();
      check("lit claim+clr byp busy", 64'(rd_busy_b[0]), 64'd0);
      nxt(); rd4(2, 4, 0, 0); settle();
      check("lit claim wins cnt", 64'(busy_cnt_b), 64'd2);
      check("lit claim wins busy", 64'(rd_busy_b[0]), 64'd1);
      nxt(); wr1(4, 64'h44);
      nxt(); settle();
      check("lit clear r4 cnt", 64'(busy_cnt_b), 64'd1);
      nxt(); wr1(2, 64'h22);

      // Full sweep.
      for (int i = 1; i < 16; i++) begin
         nxt(); claim(4'(i));
      end
      nxt(); settle();
      check("lit all busy cnt", 64'(busy_cnt_n), 64'd15);
      claim(0);
      nxt(); settle();
      check("lit claim r0 ignored", 64'(busy_cnt_b), 64'd15);
      for (int i = 1; i < 16; i++) begin
         nxt(); wr1(4'(i), 64'(i) * 64'h1111);
      end
      nxt(); rd4(1, 2, 3, 4); settle();
      check("lit all cleared cnt", 64'(busy_cnt_b), 64'd0);
      for (int p = 0; p < NRD; p++) begin
         v = 64'(p + 1) * 64'h1111;
         check("lit distinct ports", rd_data_b[p*64 +: 64], v);
      end
      nxt(); rd4(9, 9, 9, 9); settle();
      for (int p = 0; p < NRD; p++) check("lit same ports", rd_data_n[p*64 +: 64], 64'h9999);

      nxt();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
